data_sampler_mv: RTL and testbench

DATA_SAMPLER_MV -- requirements
Module: data_sampler_mv

---
 rtl/uart_rx_pkg.sv | 12 +
 rtl/sample_window.sv | 29 ++
 rtl/data_sampler_mv.sv | 107 ++++++++++
 tb/tb_data_sampler_mv.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_pkg.sv
// Shared constants and width helper for the UART receive path.
package uart_rx_pkg;

    localparam logic IDLE_LEVEL   = 1'b1;
    localparam int   SAMPLES_MAX  = 7;
    localparam int   PRESCALE_MIN = 4;

    function automatic int calc_pw(input int prescale_max);
        return $clog2(prescale_max) + 1;
    endfunction

endpackage

// File: rtl/sample_window.sv
// Combinational vote window around the bit centre; collapses to a single
// centre vote when the full window does not fit inside the prescale.
module sample_window #(
    parameter int PW      = 6,
    parameter int SAMPLES = 3
) (
    input  logic [PW-1:0] prescale_i,
    output logic [PW-1:0] lo_o,
    output logic [PW-1:0] hi_o,
    output logic          cfg_err_o
);

    localparam logic [PW-1:0] HALF    = PW'((SAMPLES - 1) / 2);
    localparam logic [PW-1:0] HALF_P1 = PW'((SAMPLES + 1) / 2);

    logic [PW-1:0] mid;
    logic [PW-1:0] lo_raw;
    logic [PW-1:0] hi_raw;

    assign mid    = prescale_i >> 1;
    assign lo_raw = mid - HALF;
    assign hi_raw = mid + HALF;

    // lo < 1 tested as mid < h+1 so the subtraction never has to go negative
    assign cfg_err_o = (mid < HALF_P1) || (hi_raw >= prescale_i);
    assign lo_o      = cfg_err_o ? mid : lo_raw;
    assign hi_o      = cfg_err_o ? mid : hi_raw;

endmodule

// File: rtl/data_sampler_mv.sv
// Majority-vote bit sampler: accumulates votes across a window centred on
// the bit and emits a one-cycle strobe with the decided bit and noise flag.
module data_sampler_mv
    import uart_rx_pkg::*;
#(
    parameter  int PRESCALE_MAX = 32,
    parameter  int SAMPLES      = 3,
    localparam int PW           = calc_pw(PRESCALE_MAX),
    localparam int CW           = $clog2(SAMPLES + 1)
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          data_samp_en,
    input  logic          RX_IN,
    input  logic [PW-1:0] prescale,
    input  logic [PW-1:0] edge_cnt,
    output logic          sampled_bit,
    output logic          sample_valid,
    output logic          noise_err,
    output logic          cfg_err,
    output logic [CW-1:0] ones_cnt
);

    localparam logic [CW-1:0] SAMPLES_C = CW'(SAMPLES);

    logic [PW-1:0] win_lo;
    logic [PW-1:0] win_hi;
    logic          cfg_now;
    logic [CW-1:0] eff_votes;
    logic [CW:0]   ones_total;
    logic          in_window;
    logic          final_vote;

    logic          sampled_bit_q, sampled_bit_d;
    logic          sample_valid_q, sample_valid_d;
    logic          noise_err_q, noise_err_d;
    logic          cfg_err_q, cfg_err_d;
    logic [CW-1:0] ones_q, ones_d;
    logic [CW-1:0] votes_q, votes_d;

    sample_window #(
        .PW      (PW),
        .SAMPLES (SAMPLES)
    ) u_window (
        .prescale_i (prescale),
        .lo_o       (win_lo),
        .hi_o       (win_hi),
        .cfg_err_o  (cfg_now)
    );

    assign eff_votes  = cfg_now ? CW'(1) : SAMPLES_C;
    assign ones_total = {1'b0, ones_q} + (CW + 1)'(RX_IN);
    assign in_window  = data_samp_en && (edge_cnt >= win_lo) && (edge_cnt <= win_hi);
    // A stalled edge counter must not produce two strobes in a row
    assign final_vote = data_samp_en && (edge_cnt == win_hi) && !sample_valid_q;

    always_comb begin
        sampled_bit_d  = sampled_bit_q;
        sample_valid_d = 1'b0;
        noise_err_d    = noise_err_q;
        cfg_err_d      = cfg_now;
        ones_d         = ones_q;
        votes_d        = votes_q;

        if (!data_samp_en) begin
            ones_d  = '0;
            votes_d = '0;
        end else if (final_vote) begin
            sampled_bit_d  = ones_total > {2'b00, eff_votes[CW-1:1]};
            noise_err_d    = (ones_total != '0) && (ones_total != {1'b0, eff_votes});
            sample_valid_d = 1'b1;
            ones_d         = '0;
            votes_d        = '0;
        end else if (edge_cnt == '0) begin
            ones_d  = '0;
            votes_d = '0;
        end else if (in_window) begin
            if (ones_q != SAMPLES_C) ones_d = ones_q + CW'(RX_IN);
            if (votes_q != SAMPLES_C) votes_d = votes_q + CW'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            sampled_bit_q  <= IDLE_LEVEL;
            sample_valid_q <= 1'b0;
            noise_err_q    <= 1'b0;
            cfg_err_q      <= 1'b0;
            ones_q         <= '0;
            votes_q        <= '0;
        end else begin
            sampled_bit_q  <= sampled_bit_d;
            sample_valid_q <= sample_valid_d;
            noise_err_q    <= noise_err_d;
            cfg_err_q      <= cfg_err_d;
            ones_q         <= ones_d;
            votes_q        <= votes_d;
        end
    end

    assign sampled_bit  = sampled_bit_q;
    assign sample_valid = sample_valid_q;
    assign noise_err    = noise_err_q;
    assign cfg_err      = cfg_err_q;
    assign ones_cnt     = ones_q;

endmodule

// File: tb/tb_data_sampler_mv.sv
// Directed bench for data_sampler_mv with 3-, 5- and 7-vote instances
// sharing one set of stimulus inputs.
module tb_data_sampler_mv;

    logic       CLK;
    logic       RST;
    logic       en;
    logic       rx;
    logic [5:0] prescale;
    logic [5:0] ec;

    logic       s3_bit, s3_valid, s3_noise, s3_cfg;
    logic [1:0] s3_ones;
    logic       s5_bit, s5_valid, s5_noise, s5_cfg;
    logic [2:0] s5_ones;
    logic       s7_bit, s7_valid, s7_noise, s7_cfg;
    logic [2:0] s7_ones;

    int tests = 0;
    int fails = 0;

    data_sampler_mv #(.PRESCALE_MAX(32), .SAMPLES(3)) u3 (
        .CLK(CLK), .RST(RST), .data_samp_en(en), .RX_IN(rx),
        .prescale(prescale), .edge_cnt(ec),
        .sampled_bit(s3_bit), .sample_valid(s3_valid), .noise_err(s3_noise),
        .cfg_err(s3_cfg), .ones_cnt(s3_ones)
    );

    data_sampler_mv #(.PRESCALE_MAX(32), .SAMPLES(5)) u5 (
        .CLK(CLK), .RST(RST), .data_samp_en(en), .RX_IN(rx),
        .prescale(prescale), .edge_cnt(ec),
        .sampled_bit(s5_bit), .sample_valid(s5_valid), .noise_err(s5_noise),
        .cfg_err(s5_cfg), .ones_cnt(s5_ones)
    );

    data_sampler_mv #(.PRESCALE_MAX(32), .SAMPLES(7)) u7 (
        .CLK(CLK), .RST(RST), .data_samp_en(en), .RX_IN(rx),
        .prescale(prescale), .edge_cnt(ec),
        .sampled_bit(s7_bit), .sample_valid(s7_valid), .noise_err(s7_noise),
        .cfg_err(s7_cfg), .ones_cnt(s7_ones)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick(input logic en_v, input logic rx_v, input int e);
        en = en_v;
        rx = rx_v;
        ec = 6'(e);
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [9:0] pat;
        logic [9:0] cap;
        int vcount;
        int last;
        int cyc;

        RST = 1'b0; en = 1'b0; rx = 1'b0; prescale = 6'd8; ec = '0;
        tick(0, 0, 0);
        tick(0, 0, 0);
        check("rst_bit",   32'(s3_bit),   1);
        check("rst_valid", 32'(s3_valid), 0);
        check("rst_noise", 32'(s3_noise), 0);
        check("rst_cfg",   32'(s3_cfg),   0);
        check("rst_ones",  32'(s3_ones),  0);
        check("rst_ones5", 32'(s5_ones),  0);
        RST = 1'b1;

        // 3 votes, prescale 8, ones at edges 3..5
        for (int e = 0; e < 8; e++) begin
            tick(1, (e >= 3 && e <= 5), e);
            if (e == 4) check("s3_ones_mid", 32'(s3_ones), 2);
            if (e == 5) begin
                check("s3_valid", 32'(s3_valid), 1);
                check("s3_bit",   32'(s3_bit),   1);
                check("s3_noise", 32'(s3_noise), 0);
                check("s3_clear", 32'(s3_ones),  0);
            end
            if (e == 6) check("s3_valid_off", 32'(s3_valid), 0);
        end
        check("s3_cfg_p8", 32'(s3_cfg), 0);

        // 5 votes, prescale 16, votes 1,0,1,0,1 on edges 6..10
        prescale = 6'd16;
        for (int e = 0; e < 16; e++) begin
            tick(1, (e == 6 || e == 8 || e == 10), e);
            if (e == 9) check("s5_ones_mid", 32'(s5_ones), 2);
            if (e == 10) begin
                check("s5_valid", 32'(s5_valid), 1);
                check("s5_bit",   32'(s5_bit),   1);
                check("s5_noise", 32'(s5_noise), 1);
            end
            if (e == 11) check("s5_valid_off", 32'(s5_valid), 0);
        end

        // 7 votes at prescale 4 collapses to a single centre vote
        prescale = 6'd4;
        for (int e = 0; e < 4; e++) begin
            tick(1, 1, e);
            if (e == 0) begin
                check("s7_cfg", 32'(s7_cfg), 1);
                check("s5_cfg", 32'(s5_cfg), 1);
                check("s3_cfg", 32'(s3_cfg), 0);
            end
            if (e == 2) begin
                check("s7_one_valid", 32'(s7_valid), 1);
                check("s7_one_bit",   32'(s7_bit),   1);
                check("s7_one_noise", 32'(s7_noise), 0);
            end
        end
        for (int e = 0; e < 4; e++) begin
            tick(1, (e != 2), e);
            if (e == 2) begin
                check("s7_zero_valid", 32'(s7_valid), 1);
                check("s7_zero_bit",   32'(s7_bit),   0);
                check("s7_zero_noise", 32'(s7_noise), 0);
                check("s7_zero_ones",  32'(s7_ones),  0);
            end
        end

        // enable dropped at edge 4
        prescale = 6'd8;
        for (int e = 0; e < 8; e++) begin
            tick(1, 1, e);
            if (e == 5) check("drop_pre_bit", 32'(s3_bit), 1);
        end
        for (int e = 0; e < 4; e++) tick(1, 1, e);
        check("drop_ones_pre", 32'(s3_ones), 1);
        vcount = 0;
        for (int e = 4; e < 8; e++) begin
            tick(0, 0, e);
            if (s3_valid) vcount++;
            if (e == 4) check("drop_ones_clr", 32'(s3_ones), 0);
        end
        check("drop_no_valid", 32'(vcount), 0);
        check("drop_bit_hold", 32'(s3_bit), 1);

        // reset mid-window
        for (int e = 0; e < 8; e++) begin
            tick(1, (e == 3), e);
            if (e == 5) begin
                check("pre_rst_bit",   32'(s3_bit),   0);
                check("pre_rst_noise", 32'(s3_noise), 1);
            end
        end
        for (int e = 0; e < 4; e++) tick(1, 1, e);
        RST = 1'b0;
        tick(1, 1, 4);
        RST = 1'b1;
        check("mid_rst_bit",   32'(s3_bit),   1);
        check("mid_rst_valid", 32'(s3_valid), 0);
        check("mid_rst_noise", 32'(s3_noise), 0);
        check("mid_rst_cfg",   32'(s3_cfg),   0);
        check("mid_rst_ones",  32'(s3_ones),  0);
        vcount = 0;
        for (int e = 5; e < 8; e++) begin
            tick(0, 1, e);
            if (s3_valid) vcount++;
        end
        check("mid_rst_no_valid", 32'(vcount), 0);
        for (int e = 0; e < 8; e++) begin
            tick(1, 0, e);
            if (e == 5) begin
                check("post_rst_valid", 32'(s3_valid), 1);
                check("post_rst_bit",   32'(s3_bit),   0);
                check("post_rst_noise", 32'(s3_noise), 0);
            end
        end

        // back-to-back windows, pattern 0x2D5 sent LSB first
        pat = 10'h2D5;
        cap = '0;
        vcount = 0;
        last = -1;
        cyc = 0;
        for (int b = 0; b < 10; b++) begin
            for (int e = 0; e < 8; e++) begin
                tick(1, pat[b], e);
                cyc++;
                check("b2b_valid", 32'(s3_valid), 32'(e == 5));
                if (s3_valid) begin
                    if (vcount < 10) cap[vcount] = s3_bit;
                    if (last >= 0) check("b2b_gap", 32'(cyc - last), 8);
                    last = cyc;
                    vcount++;
                end
            end
        end
        check("b2b_count", 32'(vcount), 10);
        check("b2b_bits",  32'(cap),    32'(pat));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
